// File: rtl/wb_writer_pkg.sv
// Shared constants for the integer register-file write-back path.
// Default widths and depth, the {addr,data} entry layout, and write-enable levels.
package wb_writer_pkg;

    localparam int   WB_RADDR_WIDTH = 5;
    localparam int   WB_RDATA_WIDTH = 32;
    localparam int   WB_DEPTH       = 2;
    localparam int   WB_ENTRY_WIDTH = WB_RADDR_WIDTH + WB_RDATA_WIDTH;
    localparam logic WRITE_ENABLE   = 1'b1;
    localparam logic WRITE_DISABLE  = 1'b0;

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH x WIDTH FIFO exposing its entries in age order (0 = head).
// Latency: push is visible at the head on the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module wb_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 37,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_dat_i,
    input  logic                        pop_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [CW-1:0]               count_o,
    output logic [WIDTH-1:0]            head_dat_o,
    output logic [DEPTH-1:0][WIDTH-1:0] age_dat_o,
    output logic [DEPTH-1:0]            age_vld_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q;
    logic [AW-1:0]               rd_ptr_q;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               cnt_d;
    logic                        push_ok;
    logic                        pop_ok;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_dat_o[k] = mem_q[rd_ptr_q + AW'(k)];
            age_vld_o[k] = (CW'(k) < cnt_q);
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Register-file write-back buffer with a registered write port and ID-stage forwarding.
// Latency: result accepted at edge N is written (we_o=1) in the cycle after edge N+1.
// Backpressure: ready_o drops when the FIFO is full; wport_busy_i stalls the drain.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int RADDR_WIDTH = WB_RADDR_WIDTH,
    parameter int RDATA_WIDTH = WB_RDATA_WIDTH,
    parameter int DEPTH       = WB_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [RADDR_WIDTH-1:0]   waddr_i,
    input  logic [RDATA_WIDTH-1:0]   wdata_i,
    input  logic                     wport_busy_i,
    output logic                     we_o,
    output logic [RADDR_WIDTH-1:0]   waddr_o,
    output logic [RDATA_WIDTH-1:0]   wdata_o,
    input  logic [RADDR_WIDTH-1:0]   fwd_raddr1_i,
    input  logic [RADDR_WIDTH-1:0]   fwd_raddr2_i,
    output logic                     fwd_hit1_o,
    output logic [RDATA_WIDTH-1:0]   fwd_data1_o,
    output logic                     fwd_hit2_o,
    output logic [RDATA_WIDTH-1:0]   fwd_data2_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int EW = RADDR_WIDTH + RDATA_WIDTH;

    logic                        full;
    logic                        empty;
    logic                        push;
    logic                        pop;
    logic [EW-1:0]               head_dat;
    logic [DEPTH-1:0][EW-1:0]    age_dat;
    logic [DEPTH-1:0]            age_vld;
    logic                        we_q;
    logic [RADDR_WIDTH-1:0]      waddr_q;
    logic [RDATA_WIDTH-1:0]      wdata_q;

    assign ready_o = !full;
    // x0 results complete the handshake but never enter the buffer.
    assign push    = valid_i && ready_o && (waddr_i != '0);
    assign pop     = !empty && !wport_busy_i;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_dat_i ({waddr_i, wdata_i}),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count_o),
        .head_dat_o (head_dat),
        .age_dat_o  (age_dat),
        .age_vld_o  (age_vld)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= WRITE_DISABLE;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (pop) begin
            we_q    <= WRITE_ENABLE;
            waddr_q <= head_dat[EW-1 -: RADDR_WIDTH];
            wdata_q <= head_dat[RDATA_WIDTH-1:0];
        end else begin
            we_q    <= WRITE_DISABLE;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

    // Oldest source first, so later (younger) matches override earlier ones.
    function automatic logic [RDATA_WIDTH:0] fwd_lookup(
        input logic [RADDR_WIDTH-1:0]  ra,
        input logic [DEPTH-1:0][EW-1:0] ent,
        input logic [DEPTH-1:0]        vld,
        input logic                    we,
        input logic [RADDR_WIDTH-1:0]  wa,
        input logic [RDATA_WIDTH-1:0]  wd
    );
        logic [RDATA_WIDTH:0] r;
        r = '0;
        if (ra != '0) begin
            if (we && (wa == ra)) begin
                r = {1'b1, wd};
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (vld[k] && (ent[k][EW-1 -: RADDR_WIDTH] == ra)) begin
                    r = {1'b1, ent[k][RDATA_WIDTH-1:0]};
                end
            end
        end
        return r;
    endfunction

    assign {fwd_hit1_o, fwd_data1_o} = fwd_lookup(fwd_raddr1_i, age_dat, age_vld, we_q, waddr_q, wdata_q);
    assign {fwd_hit2_o, fwd_data2_o} = fwd_lookup(fwd_raddr2_i, age_dat, age_vld, we_q, waddr_q, wdata_q);

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-back side of the integer register file: the regfile write port that the ID read logic depends on.
- Accepts completed results (rd address + data) from the EX/MEM path over a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle into the regfile write port, and only when that port is free.
- Provides combinational forwarding so ID reads see results that are buffered or in flight but not yet written.

Parameters:
RADDR_WIDTH, 5, register address width (matches `RADDR_WIDTH)
RDATA_WIDTH, 32, register data width (matches `RDATA_WIDTH)
DEPTH, 2, FIFO entries; power of two, >=2

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous reset, active-high
valid_i  in  1  result valid from EX/MEM
ready_o  out  1  block can accept a result this cycle
waddr_i  in  RADDR_WIDTH  destination register
wdata_i  in  RDATA_WIDTH  result data
wport_busy_i  in  1  regfile write port taken by another agent (debug); no drain this cycle
we_o  out  1  regfile write enable (registered)
waddr_o  out  RADDR_WIDTH  regfile write address (registered)
wdata_o  out  RDATA_WIDTH  regfile write data (registered)
fwd_raddr1_i  in  RADDR_WIDTH  ID read address 1
fwd_raddr2_i  in  RADDR_WIDTH  ID read address 2
fwd_hit1_o  out  1  pending write matches raddr1
fwd_data1_o  out  RDATA_WIDTH  forwarded data for raddr1
fwd_hit2_o  out  1  pending write matches raddr2
fwd_data2_o  out  RDATA_WIDTH  forwarded data for raddr2
count_o  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_i=1):
  - FIFO pointers and count_o cleared to 0.
  - we_o, waddr_o, wdata_o cleared to 0.
  - Outstanding entries are lost; the regfile is not written during or after reset.
- ready_o = (count < DEPTH). Purely from registered state; no combinational path from valid_i or wport_busy_i.
- Accept: valid_i && ready_o at a rising edge.
  - waddr_i == 0: handshake completes but the entry is dropped (x0 is never written).
  - Otherwise: written at the tail; tail pointer wraps modulo DEPTH.
- Drain, per cycle:
  - If count>0 and !wport_busy_i: head popped; on the next edge we_o=1, waddr_o/wdata_o = head contents.
  - Otherwise: we_o=0 on the next edge; waddr_o/wdata_o hold their previous values.
- Latency: with an empty FIFO and idle port, a result accepted at edge N drives we_o=1 in the cycle after edge N+1. There is no same-cycle bypass from valid_i to the write port.
- Simultaneous push and pop: count unchanged. When full, no push occurs because ready_o=0. No pass-through when full.
- Order: writes reach the regfile strictly in acceptance order. Back-to-back writes to the same register keep program order.
- Forwarding (combinational, per read port):
  - Hit when the address is nonzero and matches a valid FIFO entry or the output register (we_o=1).
  - Priority, youngest first: FIFO tail-1 down to head, then the output register.
  - On no hit, or address 0: hit=0 and data=0.
  - The output register is included because the regfile commits at the end of the we_o cycle.
- wport_busy_i held high indefinitely: FIFO fills, ready_o drops, nothing is lost.

Decomposition:
- Shared defines header: RADDR_WIDTH, RDATA_WIDTH, ZERO_REG, ZERO, WRITE_ENABLE/WRITE_DISABLE.
- Add to the same header: WB_DEPTH default, and a packed entry layout {addr,data} as width constants.
- Natural sub-module: wb_fifo, a generic DEPTH x (RADDR_WIDTH+RDATA_WIDTH) FIFO.
  - Outputs: full, empty, count, and a flat array of entries with per-entry valid bits for the forwarding search.
- wb_writer holds the output register and the priority forwarding mux.

Test Plan:
- Single write: reset, push (x5, 0x1234_5678) -> we_o=1 one cycle after the accept edge, waddr_o=5, wdata_o=0x12345678, count_o returns to 0.
- x0 drop: push (x0, 0xDEAD_BEEF) -> ready_o stays 1, count_o stays 0, we_o never asserts.
- Backpressure:
  - Stimulus: wport_busy_i=1, push (x1,0x11) then (x2,0x22).
  - count_o=2, ready_o=0, a third valid_i is not accepted.
  - Release busy: we_o writes x1 then x2 on consecutive cycles.
- Forwarding priority:
  - Stimulus: busy=1, push (x7,0xAA) then (x7,0xBB); fwd_raddr1_i=7, fwd_raddr2_i=0.
  - Expect fwd_hit1_o=1, fwd_data1_o=0xBB; fwd_hit2_o=0, fwd_data2_o=0.
  - After both drain and we_o drops: fwd_hit1_o=0.
- Continuous stream: valid_i held 1 for 8 cycles with x1..x8, busy=0 -> all 8 accepted with no stall, we_o high 8 consecutive cycles, addresses in order, count_o never exceeds 1.
- Reset mid-operation: busy=1, FIFO full, assert rst_i asynchronously -> count_o=0, we_o=0 immediately; after release, no stale write occurs.
